// File: rtl/game_ctrl_if.sv
// Button and display bus between the quiz controller and its neighbours:
// debounced button pulses in, STATE/QUE/DIN/SCORE out to the digit decoders.
interface game_ctrl_if;
  logic       BTN_START;
  logic       BTN_NEXT;
  logic       BTN_ENTER;
  logic [3:0] STATE;
  logic [3:0] QUE;
  logic [3:0] DIN;
  logic [3:0] SCORE;

  modport master (
    output BTN_START, BTN_NEXT, BTN_ENTER,
    input  STATE, QUE, DIN, SCORE
  );

  modport slave (
    input  BTN_START, BTN_NEXT, BTN_ENTER,
    output STATE, QUE, DIN, SCORE
  );
endinterface

// File: rtl/game_ctrl.sv
// Factorization quiz controller: READY/QUESTION/INPUT/GOOD/WRONG sequencing, question
// draw, answer judgement and saturating score. Optional macro TIMEOUT_EN adds an INPUT timeout.
module game_ctrl #(
  parameter int unsigned QUE_TIME   = 50_000_000,
  parameter int unsigned RES_TIME   = 50_000_000,
  parameter int unsigned INPUT_TIME = 500_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  game_ctrl_if.slave bus
);
  localparam int unsigned MAX_TIME =
    (QUE_TIME > RES_TIME) ? ((QUE_TIME > INPUT_TIME) ? QUE_TIME : INPUT_TIME)
                          : ((RES_TIME > INPUT_TIME) ? RES_TIME : INPUT_TIME);
  localparam int unsigned TMR_CLOG = $clog2(MAX_TIME);
  localparam int unsigned TMR_W    = (TMR_CLOG < 1) ? 1 : TMR_CLOG;

  localparam logic [TMR_W-1:0] QUE_LAST = TMR_W'(QUE_TIME - 1);
  localparam logic [TMR_W-1:0] RES_LAST = TMR_W'(RES_TIME - 1);
`ifdef TIMEOUT_EN
  localparam logic [TMR_W-1:0] INPUT_LAST = TMR_W'(INPUT_TIME - 1);
`endif

  typedef enum logic [3:0] {
    ST_READY    = 4'b0010,
    ST_QUESTION = 4'b0011,
    ST_INPUT    = 4'b0100,
    ST_WRONG    = 4'b0111,
    ST_GOOD     = 4'b1000
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       que_q, que_d;
  logic [3:0]       din_q, din_d;
  logic [3:0]       score_q, score_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [2:0]       rng_q, rng_d;
  logic             enter_ok;
  logic             correct;

  // Candidate factor shown for each selectable index; index 0 means nothing selected.
  function automatic logic [3:0] cand_of(input logic [3:0] idx);
    logic [3:0] c;
    case (idx)
      4'd1:    c = 4'd2;
      4'd2:    c = 4'd3;
      4'd3:    c = 4'd5;
      4'd4:    c = 4'd7;
      4'd5:    c = 4'd1;
      4'd6:    c = 4'd3;
      4'd7:    c = 4'd7;
      4'd8:    c = 4'd9;
      4'd9:    c = 4'd3;
      default: c = 4'd1;
    endcase
    return c;
  endfunction

  // A factor of 1 is trivial and never counts as a correct answer.
  function automatic logic judge(input logic [3:0] que, input logic [3:0] idx);
    logic [3:0] c;
    c = cand_of(idx);
    return (c != 4'd1) && ((que % c) == 4'd0);
  endfunction

  function automatic logic [3:0] next_idx(input logic [3:0] idx);
    return (idx >= 4'd9) ? 4'd1 : idx + 4'd1;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= 4'd9) ? 4'd9 : s + 4'd1;
  endfunction

  always_comb begin
    state_d  = state_q;
    que_d    = que_q;
    din_d    = din_q;
    score_d  = score_q;
    timer_d  = timer_q;
    rng_d    = rng_q + 3'd1;
    enter_ok = bus.BTN_ENTER && (din_q != 4'd0);
    correct  = judge(que_q, din_q);

    case (state_q)
      ST_READY: begin
        if (bus.BTN_START) begin
          que_d   = {1'b0, rng_q} + 4'd2;
          timer_d = '0;
          state_d = ST_QUESTION;
        end
      end

      ST_QUESTION: begin
        if (timer_q == QUE_LAST) begin
          state_d = ST_INPUT;
          din_d   = 4'd0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_INPUT: begin
        if (enter_ok) begin
          state_d = correct ? ST_GOOD : ST_WRONG;
          timer_d = '0;
          if (correct) score_d = sat_inc(score_q);
        end
`ifdef TIMEOUT_EN
        else if (timer_q == INPUT_LAST) begin
          state_d = ST_WRONG;
          timer_d = '0;
        end
`endif
        else begin
          // ENTER held together with NEXT suppresses the step even when DIN is 0.
          if (bus.BTN_NEXT && !bus.BTN_ENTER) din_d = next_idx(din_q);
`ifdef TIMEOUT_EN
          timer_d = timer_q + 1'b1;
`endif
        end
      end

      ST_GOOD, ST_WRONG: begin
        if (timer_q == RES_LAST) begin
          state_d = ST_READY;
          din_d   = 4'd0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_READY;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_READY;
      que_q   <= 4'd0;
      din_q   <= 4'd0;
      score_q <= 4'd0;
      timer_q <= '0;
      rng_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      que_q   <= que_d;
      din_q   <= din_d;
      score_q <= score_d;
      timer_q <= timer_d;
      rng_q   <= rng_d;
    end
  end

  assign bus.STATE = state_q;
  assign bus.QUE   = que_q;
  assign bus.DIN   = din_q;
  assign bus.SCORE = score_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: per-cycle vector table plus scripted rounds, expected outputs
// queued at drive time and compared one edge later.
`timescale 1ns/1ps
module tb_game_ctrl;
  localparam int unsigned QT = 4;
  localparam int unsigned RT = 3;
  localparam int unsigned IT = 10;

  localparam logic [3:0] RDY = 4'b0010;
  localparam logic [3:0] QST = 4'b0011;
  localparam logic [3:0] INP = 4'b0100;
  localparam logic [3:0] WRG = 4'b0111;
  localparam logic [3:0] GD  = 4'b1000;

  logic CLK = 1'b0;
  logic RST;

  game_ctrl_if bus ();

  game_ctrl #(.QUE_TIME(QT), .RES_TIME(RT), .INPUT_TIME(IT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       rst, start, nxt, ent;
    logic [3:0] st, que, din, score;
  } vec_t;

  typedef struct packed {
    logic [15:0] id;
    logic [3:0]  st, que, din, score;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  exp_t cur;
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   step_id = 0;
  int   k_edge  = 0;
  logic [3:0] score_m;

  function automatic void add_n(input int cnt, input logic r, input logic s, input logic n,
                                input logic e, input logic [3:0] st, input logic [3:0] q,
                                input logic [3:0] d, input logic [3:0] sc);
    for (int i = 0; i < cnt; i++) tbl.push_back({r, s, n, e, st, q, d, sc});
  endfunction

  function automatic void chk(input int id, input string nm, input logic [3:0] act,
                              input logic [3:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL step%0d %s: got %b, expected %b", id, nm, act, expv);
    end
  endfunction

  // Drive one cycle of inputs and queue what the outputs must be after the coming edge.
  task automatic step(input logic r, input logic s, input logic n, input logic e,
                      input logic [3:0] st, input logic [3:0] q, input logic [3:0] d,
                      input logic [3:0] sc);
    @(negedge CLK);
    RST           = r;
    bus.BTN_START = s;
    bus.BTN_NEXT  = n;
    bus.BTN_ENTER = e;
    sb.push_back({16'(step_id), st, q, d, sc});
    step_id++;
    k_edge = r ? 0 : k_edge + 1;
  endtask

  always @(posedge CLK) begin
    #1;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      chk(int'(cur.id), "STATE", bus.STATE, cur.st);
      chk(int'(cur.id), "QUE",   bus.QUE,   cur.que);
      chk(int'(cur.id), "DIN",   bus.DIN,   cur.din);
      chk(int'(cur.id), "SCORE", bus.SCORE, cur.score);
    end
  end

  // Index whose candidate divides the given question digit.
  function automatic int pick(input logic [3:0] q);
    case (q)
      4'd3, 4'd9: return 2;
      4'd5:       return 3;
      4'd7:       return 4;
      default:    return 1;
    endcase
  endfunction

  task automatic play_round(input int dsel, input bit good);
    logic [3:0] q;
    logic [3:0] rs;
    q  = 4'((k_edge % 8) + 2);
    rs = good ? GD : WRG;
    step(0, 1, 0, 0, QST, q, 4'd0, score_m);
    repeat (QT - 1) step(0, 0, 0, 0, QST, q, 4'd0, score_m);
    step(0, 0, 0, 0, INP, q, 4'd0, score_m);
    for (int i = 1; i <= dsel; i++) step(0, 0, 1, 0, INP, q, 4'(i), score_m);
    if (good && score_m < 4'd9) score_m = score_m + 4'd1;
    step(0, 0, 0, 1, rs, q, 4'(dsel), score_m);
    repeat (RT - 1) step(0, 0, 0, 0, rs, q, 4'(dsel), score_m);
    step(0, 0, 0, 0, RDY, q, 4'd0, score_m);
  endtask

  initial begin
    RST           = 1'b1;
    bus.BTN_START = 1'b0;
    bus.BTN_NEXT  = 1'b0;
    bus.BTN_ENTER = 1'b0;

    // Round 1: START on 5th edge -> QUE 6, index 1 (cand 2) is correct.
    add_n(1, 1, 0, 0, 0, RDY, 4'd0, 4'd0, 4'd0);
    add_n(4, 0, 0, 0, 0, RDY, 4'd0, 4'd0, 4'd0);
    add_n(1, 0, 1, 0, 0, QST, 4'd6, 4'd0, 4'd0);
    add_n(1, 0, 0, 1, 0, QST, 4'd6, 4'd0, 4'd0);
    add_n(1, 0, 0, 0, 1, QST, 4'd6, 4'd0, 4'd0);
    add_n(1, 0, 0, 0, 0, QST, 4'd6, 4'd0, 4'd0);
    add_n(1, 0, 0, 0, 0, INP, 4'd6, 4'd0, 4'd0);
    add_n(1, 0, 0, 0, 1, INP, 4'd6, 4'd0, 4'd0);
    add_n(1, 0, 0, 1, 0, INP, 4'd6, 4'd1, 4'd0);
    add_n(1, 0, 0, 0, 1, GD,  4'd6, 4'd1, 4'd1);
    add_n(1, 0, 0, 1, 0, GD,  4'd6, 4'd1, 4'd1);
    add_n(1, 0, 1, 0, 0, GD,  4'd6, 4'd1, 4'd1);
    add_n(1, 0, 0, 0, 0, RDY, 4'd6, 4'd0, 4'd1);
    add_n(1, 0, 0, 1, 0, RDY, 4'd6, 4'd0, 4'd1);
    add_n(1, 0, 0, 0, 1, RDY, 4'd6, 4'd0, 4'd1);
    add_n(3, 0, 0, 0, 0, RDY, 4'd6, 4'd0, 4'd1);
    // Round 2: START on edge 21 -> QUE 6 again, index 3 (cand 5) is wrong.
    add_n(1, 0, 1, 0, 0, QST, 4'd6, 4'd0, 4'd1);
    add_n(3, 0, 0, 0, 0, QST, 4'd6, 4'd0, 4'd1);
    add_n(1, 0, 0, 0, 0, INP, 4'd6, 4'd0, 4'd1);
    add_n(1, 0, 0, 1, 0, INP, 4'd6, 4'd1, 4'd1);
    add_n(1, 0, 0, 1, 0, INP, 4'd6, 4'd2, 4'd1);
    add_n(1, 0, 0, 1, 0, INP, 4'd6, 4'd3, 4'd1);
    add_n(1, 0, 0, 0, 1, WRG, 4'd6, 4'd3, 4'd1);
    add_n(2, 0, 0, 0, 0, WRG, 4'd6, 4'd3, 4'd1);
    add_n(1, 0, 0, 0, 0, RDY, 4'd6, 4'd0, 4'd1);
    // Reset mid-QUESTION, then the QUESTION timer must start over.
    add_n(1, 1, 0, 0, 0, RDY, 4'd0, 4'd0, 4'd0);
    add_n(1, 0, 1, 0, 0, QST, 4'd2, 4'd0, 4'd0);
    add_n(1, 1, 0, 0, 0, RDY, 4'd0, 4'd0, 4'd0);
    add_n(1, 0, 1, 0, 0, QST, 4'd2, 4'd0, 4'd0);
    add_n(3, 0, 0, 0, 0, QST, 4'd2, 4'd0, 4'd0);
    add_n(1, 0, 0, 0, 0, INP, 4'd2, 4'd0, 4'd0);
    // QUE 9 via START on 8th edge; NEXT+ENTER together at index 2 (cand 3), then reset mid-GOOD.
    add_n(1, 1, 0, 0, 0, RDY, 4'd0, 4'd0, 4'd0);
    add_n(7, 0, 0, 0, 0, RDY, 4'd0, 4'd0, 4'd0);
    add_n(1, 0, 1, 0, 0, QST, 4'd9, 4'd0, 4'd0);
    add_n(3, 0, 0, 0, 0, QST, 4'd9, 4'd0, 4'd0);
    add_n(1, 0, 0, 0, 0, INP, 4'd9, 4'd0, 4'd0);
    add_n(1, 0, 0, 1, 0, INP, 4'd9, 4'd1, 4'd0);
    add_n(1, 0, 0, 1, 0, INP, 4'd9, 4'd2, 4'd0);
    add_n(1, 0, 0, 1, 1, GD,  4'd9, 4'd2, 4'd1);
    add_n(1, 0, 0, 0, 0, GD,  4'd9, 4'd2, 4'd1);
    add_n(1, 1, 0, 0, 0, RDY, 4'd0, 4'd0, 4'd0);
    // Index wrap: QUE 2, nine NEXT pulses reach index 9.
    add_n(1, 0, 1, 0, 0, QST, 4'd2, 4'd0, 4'd0);
    add_n(3, 0, 0, 0, 0, QST, 4'd2, 4'd0, 4'd0);
    add_n(1, 0, 0, 0, 0, INP, 4'd2, 4'd0, 4'd0);
    for (int i = 1; i <= 9; i++) add_n(1, 0, 0, 1, 0, INP, 4'd2, 4'(i), 4'd0);
`ifdef TIMEOUT_EN
    add_n(1, 0, 0, 0, 0, WRG, 4'd2, 4'd9, 4'd0);
`else
    add_n(1, 0, 0, 1, 0, INP, 4'd2, 4'd1, 4'd0);
    add_n(1, 0, 0, 0, 1, GD,  4'd2, 4'd1, 4'd1);
`endif

    foreach (tbl[i])
      step(tbl[i].rst, tbl[i].start, tbl[i].nxt, tbl[i].ent,
           tbl[i].st, tbl[i].que, tbl[i].din, tbl[i].score);

    // Eleven correct rounds saturate SCORE at 9; a cand-1 pick is judged wrong.
    step(1, 0, 0, 0, RDY, 4'd0, 4'd0, 4'd0);
    score_m = 4'd0;
    for (int r = 0; r < 11; r++) play_round(pick(4'((k_edge % 8) + 2)), 1'b1);
    play_round(5, 1'b0);

    // Idle in INPUT: timeout to WRONG after IT cycles when enabled, otherwise wait forever.
    step(1, 0, 0, 0, RDY, 4'd0, 4'd0, 4'd0);
    step(0, 1, 0, 0, QST, 4'd2, 4'd0, 4'd0);
    repeat (QT - 1) step(0, 0, 0, 0, QST, 4'd2, 4'd0, 4'd0);
    step(0, 0, 0, 0, INP, 4'd2, 4'd0, 4'd0);
`ifdef TIMEOUT_EN
    repeat (IT - 1) step(0, 0, 0, 0, INP, 4'd2, 4'd0, 4'd0);
    step(0, 0, 0, 0, WRG, 4'd2, 4'd0, 4'd0);
`else
    repeat (100) step(0, 0, 0, 0, INP, 4'd2, 4'd0, 4'd0);
`endif

    @(negedge CLK);
    bus.BTN_START = 1'b0;
    bus.BTN_NEXT  = 1'b0;
    bus.BTN_ENTER = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
